// File: rtl/xs3_seq_ctrl.sv
`timescale 1ns/1ps
// xs3_seq_ctrl
// Converts an NDIG-digit packed BCD word to packed excess-3 by time-sharing
// one external single-digit XS3 converter. Digits are fed least-significant
// first, one per clock, and each combinational result is captured into the
// output word. Digits above 9 are still converted, and they raise out_err.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   producer has a word on in_bcd
//   in_ready   block is idle and will take a word
//   in_bcd     packed BCD input, digit 0 in [3:0]
//   cv_bin     digit presented to the shared converter
//   cv_xs3     converter result, combinational from cv_bin
//   out_valid  out_xs3/out_err hold a finished result
//   out_ready  consumer takes the result
//   out_xs3    packed XS3 result, digit 0 in [3:0]
//   out_err    at least one input digit was greater than 9
//   busy       sequencer is not idle
module xs3_seq_ctrl #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_bcd,
  output logic [3:0]        cv_bin,
  input  logic [3:0]        cv_xs3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_xs3,
  output logic              out_err,
  output logic              busy
);

  localparam int            CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [4*NDIG-1:0] hold;
  logic              err;
  logic [3:0]        cur_dig;
  logic              accept;

  function automatic logic digit_illegal(input logic [3:0] d);
    return (d > 4'd9);
  endfunction

  // Current digit of the holding register selected by the counter.
  always_comb begin
    cur_dig = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt == CW'(i)) cur_dig = hold[i*4 +: 4];
    end
  end

  assign accept = in_valid && (state == IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)    state_nxt = CONV;
      CONV:    if (cnt == LAST) state_nxt = DONE;
      DONE:    if (out_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Datapath: capture word, step the counter, collect converter results.
  // The counter stops at LAST; the next acceptance clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold    <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      out_xs3 <= '0;
    end else if (accept) begin
      hold <= in_bcd;
      cnt  <= '0;
      err  <= 1'b0;
    end else if (state == CONV) begin
      for (int i = 0; i < NDIG; i++) begin
        if (cnt == CW'(i)) out_xs3[i*4 +: 4] <= cv_xs3;
      end
      if (digit_illegal(cur_dig)) err <= 1'b1;
      if (cnt != LAST)            cnt <= cnt + 1'b1;
    end
  end

  // Outputs. The converter sees 0 whenever no conversion is running.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    cv_bin    = (state == CONV) ? cur_dig : 4'd0;
    out_err   = err;
  end

endmodule

// File: tb/tb_xs3_seq_ctrl.sv
`timescale 1ns/1ps
// Testbench for xs3_seq_ctrl: a 4-digit and a 1-digit instance, each wired to
// an ideal excess-3 converter (digit + 3, modulo 16).
module tb_xs3_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_err, busy;
  logic [15:0] in_bcd = '0, out_xs3;
  logic [3:0]  cv_bin, cv_xs3;

  logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0, out_err1, busy1;
  logic [3:0]  in_bcd1 = '0, out_xs31;
  logic [3:0]  cv_bin1, cv_xs31;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign cv_xs3  = cv_bin  + 4'd3;
  assign cv_xs31 = cv_bin1 + 4'd3;

  xs3_seq_ctrl #(.NDIG(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_bcd(in_bcd), .cv_bin(cv_bin), .cv_xs3(cv_xs3), .out_valid(out_valid),
    .out_ready(out_ready), .out_xs3(out_xs3), .out_err(out_err), .busy(busy)
  );

  xs3_seq_ctrl #(.NDIG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_bcd(in_bcd1), .cv_bin(cv_bin1), .cv_xs3(cv_xs31), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_xs3(out_xs31), .out_err(out_err1), .busy(busy1)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({in_ready, out_valid, out_err, busy} !== 4'b1000) begin n_fail++; $display("FAIL rst_ctrl: got rdy/vld/err/busy=%b want 1000", {in_ready, out_valid, out_err, busy}); end
    n_cmp++; if (out_xs3 !== 16'h0000) begin n_fail++; $display("FAIL rst_xs3: got %h want 0000", out_xs3); end
    n_cmp++; if (cv_bin !== 4'h0) begin n_fail++; $display("FAIL rst_cv_bin: got %h want 0", cv_bin); end
    n_cmp++; if ({in_ready1, out_valid1, out_err1, busy1, out_xs31, cv_bin1} !== {4'b1000, 4'h0, 4'h0}) begin n_fail++; $display("FAIL rst_dut1: got %b want 1000_0000_0000", {in_ready1, out_valid1, out_err1, busy1, out_xs31, cv_bin1}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0] w;
    w = 16'h1234;
    in_bcd = w; in_valid = 1'b1; out_ready = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    in_bcd = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++; if (cv_bin !== w[i*4 +: 4]) begin n_fail++; $display("FAIL basic_cv_bin%0d: got %h want %h", i, cv_bin, w[i*4 +: 4]); end
      n_cmp++; if ({out_valid, in_ready, busy} !== 3'b001) begin n_fail++; $display("FAIL basic_conv%0d: got vld/rdy/busy=%b want 001", i, {out_valid, in_ready, busy}); end
    end
    @(negedge clk);
    n_cmp++; if ({out_valid, out_err, in_ready} !== 3'b100) begin n_fail++; $display("FAIL basic_done: got vld/err/rdy=%b want 100", {out_valid, out_err, in_ready}); end
    n_cmp++; if (out_xs3 !== 16'h4567) begin n_fail++; $display("FAIL basic_xs3: got %h want 4567", out_xs3); end
    n_cmp++; if (cv_bin !== 4'h0) begin n_fail++; $display("FAIL basic_cv_done: got %h want 0", cv_bin); end
    @(negedge clk);
    n_cmp++; if ({out_valid, in_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL basic_idle: got vld/rdy/busy=%b want 010", {out_valid, in_ready, busy}); end
    n_cmp++; if (out_xs3 !== 16'h4567) begin n_fail++; $display("FAIL basic_keep: got %h want 4567", out_xs3); end
  endtask

  task automatic test_back_to_back;
    in_bcd = 16'h9870; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_bcd = 16'h0000;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_rdy: got %b want 0", in_ready); end
    repeat (4) @(negedge clk);
    n_cmp++; if ({out_valid, out_err, in_ready} !== 3'b100) begin n_fail++; $display("FAIL b2b_done1: got vld/err/rdy=%b want 100", {out_valid, out_err, in_ready}); end
    n_cmp++; if (out_xs3 !== 16'hCBA3) begin n_fail++; $display("FAIL b2b_xs3_1: got %h want CBA3", out_xs3); end
    @(negedge clk);
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL b2b_idle: got rdy/vld=%b want 10", {in_ready, out_valid}); end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if ({busy, cv_bin} !== {1'b1, 4'h0}) begin n_fail++; $display("FAIL b2b_conv2: got busy/cv=%b/%h want 1/0", busy, cv_bin); end
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early: got vld %b want 0", out_valid); end
    @(negedge clk);
    n_cmp++; if ({out_valid, out_err} !== 2'b10) begin n_fail++; $display("FAIL b2b_done2: got vld/err=%b want 10", {out_valid, out_err}); end
    n_cmp++; if (out_xs3 !== 16'h3333) begin n_fail++; $display("FAIL b2b_xs3_2: got %h want 3333", out_xs3); end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    in_bcd = 16'h12A4; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if ({out_valid, out_err} !== 2'b11) begin n_fail++; $display("FAIL ill_flag: got vld/err=%b want 11", {out_valid, out_err}); end
    n_cmp++; if (out_xs3 !== 16'h45D7) begin n_fail++; $display("FAIL ill_xs3: got %h want 45D7", out_xs3); end
    @(negedge clk);
    in_bcd = 16'h0001; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if ({out_valid, out_err} !== 2'b10) begin n_fail++; $display("FAIL ill_clear: got vld/err=%b want 10", {out_valid, out_err}); end
    n_cmp++; if (out_xs3 !== 16'h3334) begin n_fail++; $display("FAIL ill_next_xs3: got %h want 3334", out_xs3); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int k;
    out_ready = 1'b0;
    in_bcd = 16'h0F89; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++; if (k !== 4) begin n_fail++; $display("FAIL bp_latency: got %0d cycles want 4", k); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if ({out_valid, out_err, in_ready, out_xs3} !== {3'b110, 16'h32BC}) begin n_fail++; $display("FAIL bp_hold%0d: got vld/err/rdy=%b xs3=%h want 110 32BC", i, {out_valid, out_err, in_ready}, out_xs3); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got vld/rdy=%b want 01", {out_valid, in_ready}); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    in_bcd = 16'h5678; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (cv_bin !== 4'h7) begin n_fail++; $display("FAIL rmid_cv_before: got %h want 7", cv_bin); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({out_valid, busy, in_ready} !== 3'b001) begin n_fail++; $display("FAIL rmid_ctrl: got vld/busy/rdy=%b want 001", {out_valid, busy, in_ready}); end
    n_cmp++; if ({out_xs3, cv_bin} !== 20'h0) begin n_fail++; $display("FAIL rmid_data: got xs3=%h cv=%h want 0000 0", out_xs3, cv_bin); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++; if ({out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rmid_quiet%0d: got vld/busy=%b want 00", i, {out_valid, busy}); end
    end
    in_bcd = 16'h0042; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if ({out_valid, out_err, out_xs3} !== {2'b10, 16'h3375}) begin n_fail++; $display("FAIL rmid_after: got vld/err=%b xs3=%h want 10 3375", {out_valid, out_err}, out_xs3); end
    @(negedge clk);
  endtask

  task automatic test_ndig1;
    in_bcd1 = 4'h9; in_valid1 = 1'b1; out_ready1 = 1'b1;
    n_cmp++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL n1_in_ready: got %b want 1", in_ready1); end
    @(negedge clk);
    in_valid1 = 1'b0;
    n_cmp++; if ({cv_bin1, out_valid1, busy1} !== {4'h9, 2'b01}) begin n_fail++; $display("FAIL n1_conv: got cv=%h vld/busy=%b want 9 01", cv_bin1, {out_valid1, busy1}); end
    @(negedge clk);
    n_cmp++; if ({out_valid1, out_err1, out_xs31} !== {2'b10, 4'hC}) begin n_fail++; $display("FAIL n1_done: got vld/err=%b xs3=%h want 10 C", {out_valid1, out_err1}, out_xs31); end
    @(negedge clk);
    n_cmp++; if ({out_valid1, in_ready1} !== 2'b01) begin n_fail++; $display("FAIL n1_idle: got vld/rdy=%b want 01", {out_valid1, in_ready1}); end
    in_bcd1 = 4'hB; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    @(negedge clk);
    n_cmp++; if ({out_valid1, out_err1, out_xs31} !== {2'b11, 4'hE}) begin n_fail++; $display("FAIL n1_illegal: got vld/err=%b xs3=%h want 11 E", {out_valid1, out_err1}, out_xs31); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_ndig1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
